circ05_sig_capture: RTL and testbench
=====================================

// Module: circ05_sig_capture
// PURPOSE
//  Downstream capture stage for the circ05 netlist. Compacts its outputs u (combinational from b,c) and
//  v (registered, multi-stage) into a MISR signature over a programmed number of clk cycles.
//  Start/busy/done/ack handshake. Discards a warm-up window so the v pipeline flushes before compaction.
//  Gives the STA labs a cycle-exact, checkable observable for the circ05 paths.
// PARAMETERS
//  SIG_W   16       signature width, >= 2
//  POLY    16'h1021 feedback polynomial XORed in when sig MSB shifts out
//  SEED    16'h0000 signature value loaded on start
//  CNT_W   8        width of len and of the sample counter
//  WARMUP  2        cycles ignored after start before sampling, 0..15
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      begin capture; sampled only in IDLE
//  abort      in   1      cancel capture in WARM/RUN
//  len        in   CNT_W  number of samples to compact; sampled with start
//  u_in       in   1      circ05 output u
//  v_in       in   1      circ05 output v
//  ack        in   1      consumer accepts signature; sampled only in HOLD
//  busy       out  1      high in WARM or RUN
//  done       out  1      high in HOLD; sig valid and stable
//  sig        out  SIG_W  signature register
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous and active-high, rst.
//   All state is in flops on clk rising edge. All outputs are registered.
//  Reset: state=IDLE, sig=0, busy=0, done=0, sample counter=0, warm-up counter=0.
//  State IDLE:
//   start=1, abort=0, len!=0 -> sig<=SEED, cnt<=len.
//     Next state is WARM with wcnt<=WARMUP, or RUN if WARMUP==0.
//   start=1, len==0 -> sig<=SEED, go to HOLD. done is high the cycle after start.
//   start=1 with abort=1 -> abort wins; stay in IDLE.
//  State WARM:
//   u_in/v_in ignored; wcnt decrements each cycle.
//   wcnt==1 -> RUN, so exactly WARMUP cycles are spent in WARM.
//  State RUN, each edge:
//   sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {0.., v_in, u_in}
//   cnt decrements. cnt==1 on the sampling edge -> HOLD.
//   Exactly len samples are taken.
//  Timing: start sampled at edge t0.
//   Samples are taken at edges t0+WARMUP+1 .. t0+WARMUP+len.
//   done rises after edge t0+WARMUP+len.
//  Abort in WARM/RUN -> IDLE next edge. done stays 0 and sig holds its partial value.
//  State HOLD:
//   done=1 and sig is frozen. start is ignored.
//   ack=1 -> IDLE; done falls after that edge.
//   The next start is accepted the following cycle.
//  start while busy is ignored. abort in IDLE or HOLD has no effect.
//  len of all-ones gives 2^CNT_W-1 samples. There is no wrap and no overflow.
//  rst asserted mid-capture: immediate return to reset values. No done pulse is produced.
// TESTING
//  T1 len=1, u=1, v=0 on the sample edge, WARMUP=2:
//     busy high for 3 cycles; done after edge t0+3; sig=16'h0001.
//  T2 len=2, u=v=1 both samples: sig=16'h0003 then 16'h0005; done held until ack, falls one cycle later.
//  T3 SEED=16'h8000, len=1, u=v=0: sig=16'h1021, which exercises POLY feedback.
//  T4 len=0 with start: done=1 the next cycle, sig=SEED, busy never high.
//  T5 abort on the 3rd RUN cycle of len=10: IDLE next edge, done=0; a new start is accepted the cycle after.
//  T6 rst pulse mid-RUN, then start or ack asserted in HOLD:
//     all outputs return to 0 asynchronously; start is ignored in HOLD;
//     simultaneous start+abort in IDLE does not start.

Source files
------------

// File: rtl/circ05_sig_capture.sv
// ---------------------------------------------------------------------------
// circ05_sig_capture
//
// Downstream capture stage for the circ05 netlist. The two circ05 outputs,
// u (combinational from b,c) and v (registered, multi-stage), are compacted
// into a MISR signature over a programmed number of clock cycles. A short
// warm-up window is skipped after start so the v pipeline has flushed
// before anything is folded into the signature.
//
// Handshake: start (sampled in IDLE) -> busy while warming up / running ->
// done in HOLD with sig frozen -> ack returns to IDLE.
//
// Parameters
//   SIG_W   signature width (>= 2)
//   POLY    feedback polynomial, XORed in when the signature MSB shifts out
//   SEED    signature value loaded on start
//   CNT_W   width of len and of the sample counter
//   WARMUP  cycles ignored after start before sampling (0..15)
//
// Ports
//   clk     in   1      single clock, rising edge
//   rst     in   1      asynchronous reset, active-high
//   start   in   1      begin capture; only looked at in IDLE
//   abort   in   1      cancel capture while warming up or running
//   len     in   CNT_W  number of samples to compact; captured with start
//   u_in    in   1      circ05 output u
//   v_in    in   1      circ05 output v
//   ack     in   1      consumer accepts the signature; only looked at in HOLD
//   busy    out  1      high while warming up or running
//   done    out  1      high in HOLD; sig is valid and stable
//   sig     out  SIG_W  signature register
// ---------------------------------------------------------------------------
module circ05_sig_capture #(
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0]  SEED   = SIG_W'(16'h0000),
    parameter int                CNT_W  = 8,
    parameter int                WARMUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] len,
    input  logic             u_in,
    input  logic             v_in,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_RUN,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       WARM_ONE  = 4'd1;
    localparam logic [3:0]       WARM_INIT = 4'(WARMUP);

    state_t             state;
    state_t             state_next;
    logic [SIG_W-1:0]   sig_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [3:0]         wcnt;
    logic [3:0]         wcnt_next;

    logic [SIG_W-1:0]   shifted;
    logic [SIG_W-1:0]   feedback;
    logic [SIG_W-1:0]   inject;
    logic [SIG_W-1:0]   misr_next;

    // One MISR step: shift left, fold the polynomial back in when the MSB
    // falls off, and inject the two circ05 observables into the low bits.
    always_comb begin
        shifted    = {sig[SIG_W-2:0], 1'b0};
        feedback   = sig[SIG_W-1] ? POLY : '0;
        inject     = '0;
        inject[1]  = v_in;
        inject[0]  = u_in;
        misr_next  = shifted ^ feedback ^ inject;
    end

    // Next-state logic. Abort beats start in IDLE and beats completion in
    // RUN; an aborting edge leaves sig untouched so the partial value stays
    // visible. A zero length skips straight to HOLD with the seed loaded.
    always_comb begin
        state_next = state;
        sig_next   = sig;
        cnt_next   = cnt;
        wcnt_next  = wcnt;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    sig_next = SEED;
                    if (len == '0) begin
                        state_next = S_HOLD;
                    end else begin
                        cnt_next = len;
                        if (WARMUP == 0) begin
                            state_next = S_RUN;
                        end else begin
                            state_next = S_WARM;
                            wcnt_next  = WARM_INIT;
                        end
                    end
                end
            end

            S_WARM: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    wcnt_next = wcnt - WARM_ONE;
                    if (wcnt == WARM_ONE) begin
                        state_next = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    sig_next = misr_next;
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_next = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (ack) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. busy and done are decoded from the
    // next state so they are true flops that line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sig   <= '0;
            cnt   <= '0;
            wcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            sig   <= sig_next;
            cnt   <= cnt_next;
            wcnt  <= wcnt_next;
            busy  <= (state_next == S_WARM) || (state_next == S_RUN);
            done  <= (state_next == S_HOLD);
        end
    end

endmodule

// File: tb/tb_circ05_sig_capture.sv
// ---------------------------------------------------------------------------
// tb_circ05_sig_capture
//
// Directed bench for circ05_sig_capture. Two instances share all inputs:
// dut_a uses SEED=0, dut_b uses SEED=16'h8000 so POLY feedback and seed
// loading are visible. Inputs change and outputs are sampled 1 time unit
// after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_circ05_sig_capture;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  len;
    logic        u_in;
    logic        v_in;
    logic        ack;
    logic        busy_a;
    logic        done_a;
    logic [15:0] sig_a;
    logic        busy_b;
    logic        done_b;
    logic [15:0] sig_b;

    int n_compared;
    int n_mismatched;

    circ05_sig_capture #(
        .SIG_W  (16),
        .POLY   (16'h1021),
        .SEED   (16'h0000),
        .CNT_W  (8),
        .WARMUP (2)
    ) dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .len   (len),
        .u_in  (u_in),
        .v_in  (v_in),
        .ack   (ack),
        .busy  (busy_a),
        .done  (done_a),
        .sig   (sig_a)
    );

    circ05_sig_capture #(
        .SIG_W  (16),
        .POLY   (16'h1021),
        .SEED   (16'h8000),
        .CNT_W  (8),
        .WARMUP (2)
    ) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .len   (len),
        .u_in  (u_in),
        .v_in  (v_in),
        .ack   (ack),
        .busy  (busy_b),
        .done  (done_b),
        .sig   (sig_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic s, input logic a, input logic [7:0] l,
                                  input logic u, input logic v, input logic k);
        start = s;
        abort = a;
        len   = l;
        u_in  = u;
        v_in  = v;
        ack   = k;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        check_output("reset_sig_a", sig_a, 16'h0000);
        check_output("reset_sig_b", sig_b, 16'h0000);
        check_bit("reset_busy", busy_a, 1'b0);
        check_bit("reset_done", done_a, 1'b0);
        rst = 1'b0;
        tick();

        // T1: len=1, u=1 v=0 on the sample edge
        $display("[TB] T1 len=1");
        apply_stimulus(1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t1_busy_c1", busy_a, 1'b1);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t1_busy_c2", busy_a, 1'b1);
        tick();
        check_bit("t1_busy_c3", busy_a, 1'b1);
        check_bit("t1_done_early", done_a, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_bit("t1_busy_end", busy_a, 1'b0);
        check_bit("t1_done", done_a, 1'b1);
        check_output("t1_sig_a", sig_a, 16'h0001);
        check_output("t1_sig_b", sig_b, 16'h1020);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_bit("t1_done_ack", done_a, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // T2: len=2, u=v=1 both samples; HOLD until ack; start ignored in HOLD
        $display("[TB] T2 len=2");
        apply_stimulus(1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_output("t2_sig_s1", sig_a, 16'h0003);
        check_bit("t2_done_s1", done_a, 1'b0);
        tick();
        check_output("t2_sig_s2", sig_a, 16'h0005);
        check_bit("t2_done_s2", done_a, 1'b1);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_bit("t2_done_held", done_a, 1'b1);
        check_output("t2_sig_held", sig_a, 16'h0005);
        apply_stimulus(1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check_bit("t6_hold_start_done", done_a, 1'b1);
        check_bit("t6_hold_start_busy", busy_a, 1'b0);
        check_output("t6_hold_start_sig", sig_a, 16'h0005);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_bit("t2_done_fall", done_a, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // T3: len=1, u=v=0; dut_b seed 8000 exercises POLY feedback
        $display("[TB] T3 poly feedback");
        apply_stimulus(1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check_bit("t3_done", done_b, 1'b1);
        check_output("t3_sig_a", sig_a, 16'h0000);
        check_output("t3_sig_b", sig_b, 16'h1021);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // T4: len=0 -> done next cycle with sig=SEED, busy never high
        $display("[TB] T4 len=0");
        apply_stimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_bit("t4_done", done_b, 1'b1);
        check_bit("t4_busy", busy_b, 1'b0);
        check_output("t4_sig_a", sig_a, 16'h0000);
        check_output("t4_sig_b", sig_b, 16'h8000);
        apply_stimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_bit("t4_abort_in_hold", done_b, 1'b1);
        check_output("t4_sig_b_frozen", sig_b, 16'h8000);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // T5: abort on the 3rd RUN cycle of len=10, then restart
        $display("[TB] T5 abort");
        apply_stimulus(1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("t5_sig_r1", sig_a, 16'h0001);
        tick();
        check_output("t5_sig_r2", sig_a, 16'h0003);
        apply_stimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t5_busy_abort", busy_a, 1'b0);
        check_bit("t5_done_abort", done_a, 1'b0);
        check_output("t5_sig_a_partial", sig_a, 16'h0003);
        check_output("t5_sig_b_partial", sig_b, 16'h2041);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t5_done_idle", done_a, 1'b0);
        check_output("t5_sig_a_kept", sig_a, 16'h0003);
        apply_stimulus(1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t5_restart_busy", busy_a, 1'b1);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check_bit("t5_restart_done", done_a, 1'b1);
        check_output("t5_restart_sig", sig_a, 16'h0002);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // T6: asynchronous reset mid-RUN, then start+abort in IDLE
        $display("[TB] T6 reset mid-run");
        apply_stimulus(1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_bit("t6_busy_pre", busy_a, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_bit("t6_rst_busy", busy_a, 1'b0);
        check_bit("t6_rst_done", done_a, 1'b0);
        check_output("t6_rst_sig_a", sig_a, 16'h0000);
        check_output("t6_rst_sig_b", sig_b, 16'h0000);
        #1;
        rst = 1'b0;
        tick();
        check_bit("t6_no_done_pulse", done_a, 1'b0);
        check_bit("t6_idle_busy", busy_a, 1'b0);
        apply_stimulus(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t6_start_abort_busy", busy_a, 1'b0);
        check_bit("t6_start_abort_done", done_a, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t6_still_idle", busy_a, 1'b0);

        // len all-ones: 255 samples, done after edge t0+257
        $display("[TB] T7 len=255");
        apply_stimulus(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            tick();
        end
        check_bit("t7_busy_last", busy_a, 1'b1);
        check_bit("t7_done_early", done_a, 1'b0);
        tick();
        check_bit("t7_done", done_a, 1'b1);
        check_bit("t7_busy_end", busy_a, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_bit("t7_done_ack", done_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
